tap_ir_controller: RTL and testbench
====================================

Name: tap_ir_controller

Overview:
- IEEE 1149.1-style TAP state machine, 2-bit instruction register and 1-bit bypass register.
- Directly upstream of the 4:1 TDO select mux. It drives that mux's `ir1`/`ir2` selects and its `bypass_tdo` input.
- Also generates the shift-enable and capture/update strobes for the boundary-scan and internal-scan chains built from scanff cells.
- Runs in the single test clock domain.

Parameters:
- IR_RESET, 2'b10, value `{ir2,ir1}` is loaded with on reset and in Test-Logic-Reset (BYPASS).
- IR_CAPTURE, 2'b01, value loaded into the IR shift stage in Capture-IR.

Ports:
- clock  input  1  test clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- tms  input  1  test mode select; sampled every rising edge
- tdi  input  1  serial test data in
- ir1  output  1  IR bit 0, mux select
- ir2  output  1  IR bit 1, mux select
- bypass_tdo  output  1  bypass register output
- ir_tdo  output  1  IR shift-stage LSB (serial out during Shift-IR)
- tdo_sel_ir  output  1  high in Shift-IR; downstream selects `ir_tdo` over the data mux
- shift_dr  output  1  high in Shift-DR
- capture_dr  output  1  high in Capture-DR
- update_dr  output  1  high in Update-DR
- bs_se  output  1  `shift_dr` AND `{ir2,ir1}`==2'b01
- int_se  output  1  `shift_dr` AND `{ir2,ir1}`==2'b11
- tlr  output  1  high in Test-Logic-Reset
- state  output  4  current state code

Behaviour:
- Instruction decode, `{ir2,ir1}`:
  - 00: reserved; data mux drives TDO = 0
  - 01: boundary scan
  - 10: BYPASS
  - 11: internal scan
- State codes:
  - TLR=F, RTI=C
  - SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D
- Transitions, written as (tms=0 / tms=1):
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - CapDR: ShDR / Ex1DR
  - ShDR: ShDR / Ex1DR
  - Ex1DR: PauseDR / UpdDR
  - PauseDR: PauseDR / Ex2DR
  - Ex2DR: ShDR / UpdDR
  - UpdDR: RTI / SelDR
  - SelIR: CapIR / TLR
  - IR branch (CapIR..UpdIR) mirrors the DR branch.
- All control outputs are Moore, decoded from the registered `state` only; no combinational path from `tms`.
- Reset: `reset`=1 at a rising edge sets:
  - `state`=F, IR=IR_RESET, IR shift stage=2'b00, bypass reg=0
  - Outputs after that edge: `ir2`=1, `ir1`=0, `tlr`=1, all other strobes 0, `ir_tdo`=0, `bypass_tdo`=0
  - Reset overrides `tms` and any operation in progress, including mid-shift; the partial shift contents are discarded.
- IR shift stage (2 bits), per rising edge, by current state:
  - CapIR: load IR_CAPTURE.
  - ShIR: shift right; `tdi` enters bit 1, bit 0 leaves on `ir_tdo`.
  - All other states: hold.
- IR, per rising edge:
  - UpdIR: IR takes the shift-stage value. The new `ir1`/`ir2` are visible the cycle after UpdIR.
  - TLR: IR forced to IR_RESET every edge.
  - All other states: hold. IR never changes during Shift-IR or Pause-IR.
- Bypass register, per rising edge:
  - CapDR: load 0.
  - ShDR: load `tdi`.
  - All other states: hold.
  - It operates regardless of instruction; only the mux selects it.
- Latency:
  - `tdi` to `bypass_tdo`: 1 clock.
  - `tdi` to `ir_tdo` through the IR: 2 clocks.
- Exit convention: the edge that leaves ShDR/ShIR (tms=1) still performs one shift, as in 1149.1.
- From any state, 5 consecutive edges with tms=1 reach TLR.
- Update-DR with IR=00 has no side effects beyond `update_dr` asserting.

Test Plan:
1. Reset asserted 1 cycle from ShIR -> `state`=F, `{ir2,ir1}`=10, `tlr`=1, `tdo_sel_ir`=0, `bypass_tdo`=0.
2. From RTI with arbitrary state history, tms=1×5 -> `state`=F by the 5th edge at the latest; then tms=0 -> `state`=C.
3. IR load of 11:
   - tms 1,1,0,0 from RTI -> ShIR (A), with `tdo_sel_ir`=1.
   - Shift `tdi`=1,1 with tms 0,1 -> `ir_tdo` shows 1 then 0 (captured 01, LSB first).
   - tms 1 -> UpdIR; next cycle `{ir2,ir1}`=11.
   - Then enter ShDR -> `int_se`=1, `bs_se`=0.
4. BYPASS: after reset, enter ShDR and drive `tdi`=1,0,1,1 -> `bypass_tdo`=0(captured),1,0,1,1, one-clock lag; `bs_se`=`int_se`=0.
5. Pause-IR: shift one bit, go Ex1IR->PauseIR for 3 cycles, then Ex2IR->ShIR and shift one more bit -> shift stage holds during pause; IR reaches 2'b01 only after UpdIR.
6. Load IR=01 then tms=1×5 -> `{ir2,ir1}` returns to 10 on the edge in TLR; `bs_se` never asserts outside ShDR.

Source files
------------

// File: rtl/tap_ir_controller.sv
// tap_ir_controller
//   IEEE 1149.1-style TAP controller with a 2-bit instruction register and
//   a 1-bit bypass register. Feeds the downstream 4:1 TDO select mux
//   (ir1/ir2 selects, bypass_tdo) and produces the shift-enable and
//   capture/update strobes for the boundary-scan and internal-scan chains.
//
// Ports:
//   clock       in   test clock, all state changes on the rising edge
//   reset       in   synchronous, active-high reset
//   tms         in   test mode select
//   tdi         in   serial test data in
//   ir1, ir2    out  instruction register bits 0 and 1 (mux selects)
//   bypass_tdo  out  bypass register output
//   ir_tdo      out  LSB of the IR shift stage (serial out in Shift-IR)
//   tdo_sel_ir  out  high in Shift-IR
//   shift_dr    out  high in Shift-DR
//   capture_dr  out  high in Capture-DR
//   update_dr   out  high in Update-DR
//   bs_se       out  boundary-scan shift enable (Shift-DR, IR=01)
//   int_se      out  internal-scan shift enable (Shift-DR, IR=11)
//   tlr         out  high in Test-Logic-Reset
//   state       out  current TAP state code
module tap_ir_controller #(
  parameter logic [1:0] IR_RESET   = 2'b10,
  parameter logic [1:0] IR_CAPTURE = 2'b01
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tms,
  input  logic       tdi,
  output logic       ir1,
  output logic       ir2,
  output logic       bypass_tdo,
  output logic       ir_tdo,
  output logic       tdo_sel_ir,
  output logic       shift_dr,
  output logic       capture_dr,
  output logic       update_dr,
  output logic       bs_se,
  output logic       int_se,
  output logic       tlr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    ST_TLR     = 4'hF,
    ST_RTI     = 4'hC,
    ST_SEL_DR  = 4'h7,
    ST_CAP_DR  = 4'h6,
    ST_SH_DR   = 4'h2,
    ST_EX1_DR  = 4'h1,
    ST_PAUSE_DR= 4'h3,
    ST_EX2_DR  = 4'h0,
    ST_UPD_DR  = 4'h5,
    ST_SEL_IR  = 4'h4,
    ST_CAP_IR  = 4'hE,
    ST_SH_IR   = 4'hA,
    ST_EX1_IR  = 4'h9,
    ST_PAUSE_IR= 4'hB,
    ST_EX2_IR  = 4'h8,
    ST_UPD_IR  = 4'hD
  } tap_state_t;

  tap_state_t state_reg;
  tap_state_t state_next;

  logic [1:0] ir_reg;        // active instruction {ir2, ir1}
  logic [1:0] ir_shift_reg;  // IR capture/shift stage
  logic       bypass_reg;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_TLR;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_TLR:      state_next = tms ? ST_TLR      : ST_RTI;
      ST_RTI:      state_next = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   state_next = tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   state_next = tms ? ST_EX1_DR   : ST_SH_DR;
      ST_SH_DR:    state_next = tms ? ST_EX1_DR   : ST_SH_DR;
      ST_EX1_DR:   state_next = tms ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: state_next = tms ? ST_EX2_DR   : ST_PAUSE_DR;
      ST_EX2_DR:   state_next = tms ? ST_UPD_DR   : ST_SH_DR;
      ST_UPD_DR:   state_next = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   state_next = tms ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   state_next = tms ? ST_EX1_IR   : ST_SH_IR;
      ST_SH_IR:    state_next = tms ? ST_EX1_IR   : ST_SH_IR;
      ST_EX1_IR:   state_next = tms ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: state_next = tms ? ST_EX2_IR   : ST_PAUSE_IR;
      ST_EX2_IR:   state_next = tms ? ST_UPD_IR   : ST_SH_IR;
      ST_UPD_IR:   state_next = tms ? ST_SEL_DR   : ST_RTI;
      default:     state_next = ST_TLR;
    endcase
  end

  // ---------------------------------------------------------------------
  // Data registers. Their actions depend on the state being left, so the
  // edge that exits Shift-DR/Shift-IR still shifts once.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      ir_reg       <= IR_RESET;
      ir_shift_reg <= 2'b00;
      bypass_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_CAP_IR: ir_shift_reg <= IR_CAPTURE;
        ST_SH_IR:  ir_shift_reg <= {tdi, ir_shift_reg[1]};
        default:   ir_shift_reg <= ir_shift_reg;
      endcase

      case (state_reg)
        ST_UPD_IR: ir_reg <= ir_shift_reg;
        ST_TLR:    ir_reg <= IR_RESET;
        default:   ir_reg <= ir_reg;
      endcase

      case (state_reg)
        ST_CAP_DR: bypass_reg <= 1'b0;
        ST_SH_DR:  bypass_reg <= tdi;
        default:   bypass_reg <= bypass_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Moore outputs, decoded from registered state only
  // ---------------------------------------------------------------------
  always_comb begin
    tdo_sel_ir = 1'b0;
    shift_dr   = 1'b0;
    capture_dr = 1'b0;
    update_dr  = 1'b0;
    tlr        = 1'b0;
    case (state_reg)
      ST_SH_IR:  tdo_sel_ir = 1'b1;
      ST_SH_DR:  shift_dr   = 1'b1;
      ST_CAP_DR: capture_dr = 1'b1;
      ST_UPD_DR: update_dr  = 1'b1;
      ST_TLR:    tlr        = 1'b1;
      default:   ;
    endcase
    bs_se      = shift_dr && (ir_reg == 2'b01);
    int_se     = shift_dr && (ir_reg == 2'b11);
    ir1        = ir_reg[0];
    ir2        = ir_reg[1];
    ir_tdo     = ir_shift_reg[0];
    bypass_tdo = bypass_reg;
    state      = state_reg;
  end

endmodule

// File: tb/tb_tap_ir_controller.sv
module tb_tap_ir_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tms   = 1'b0;
  logic       tdi   = 1'b0;
  logic       ir1, ir2, bypass_tdo, ir_tdo, tdo_sel_ir;
  logic       shift_dr, capture_dr, update_dr, bs_se, int_se, tlr;
  logic [3:0] state;

  tap_ir_controller #(.IR_RESET(2'b10), .IR_CAPTURE(2'b01)) dut (
    .clock(clock), .reset(reset), .tms(tms), .tdi(tdi),
    .ir1(ir1), .ir2(ir2), .bypass_tdo(bypass_tdo), .ir_tdo(ir_tdo),
    .tdo_sel_ir(tdo_sel_ir), .shift_dr(shift_dr), .capture_dr(capture_dr),
    .update_dr(update_dr), .bs_se(bs_se), .int_se(int_se), .tlr(tlr),
    .state(state)
  );

  always #5 clock = ~clock;

  // state codes
  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC;
  localparam logic [3:0] S_SDR = 4'h7, S_CDR = 4'h6, S_SHDR = 4'h2, S_E1DR = 4'h1, S_UDR = 4'h5;
  localparam logic [3:0] S_SIR = 4'h4, S_CIR = 4'hE, S_SHIR = 4'hA, S_E1IR = 4'h9;
  localparam logic [3:0] S_PIR = 4'hB, S_E2IR = 4'h8, S_UIR = 4'hD;

  // check mask bits: state, ir, ir_tdo, bypass_tdo, control strobes
  localparam logic [4:0] M_S = 5'b10000, M_IR = 5'b01000, M_IT = 5'b00100;
  localparam logic [4:0] M_BP = 5'b00010, M_C = 5'b00001, M_ALL = 5'b11111;

  // strobes {tdo_sel_ir, shift_dr, capture_dr, update_dr, bs_se, int_se, tlr}
  localparam logic [6:0] C_NONE = 7'b0000000, C_TLR = 7'b0000001, C_SHIR = 7'b1000000;
  localparam logic [6:0] C_SHDR = 7'b0100000, C_SHDR_BS = 7'b0100100, C_SHDR_INT = 7'b0100010;
  localparam logic [6:0] C_CAPDR = 7'b0010000, C_UPDDR = 7'b0001000;

  typedef struct {
    string      tag;
    logic [4:0] chk;
    logic [3:0] st;
    logic [1:0] ir;
    logic       it;
    logic       bp;
    logic [6:0] ctl;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic cmp(input string tag, input string field, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%0h required=%0h", tag, field, act, req);
    end
  endtask

  // Monitor: every edge produces one response; pop its expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk[4]) cmp(e.tag, "state", {4'h0, state}, {4'h0, e.st});
        if (e.chk[3]) cmp(e.tag, "ir", {6'h0, ir2, ir1}, {6'h0, e.ir});
        if (e.chk[2]) cmp(e.tag, "ir_tdo", {7'h0, ir_tdo}, {7'h0, e.it});
        if (e.chk[1]) cmp(e.tag, "bypass_tdo", {7'h0, bypass_tdo}, {7'h0, e.bp});
        if (e.chk[0]) cmp(e.tag, "ctl",
                          {1'b0, tdo_sel_ir, shift_dr, capture_dr, update_dr, bs_se, int_se, tlr},
                          {1'b0, e.ctl});
        $display("txn %-14s state=%h ir=%b%b ir_tdo=%b byp=%b ctl=%b%b%b%b%b%b%b",
                 e.tag, state, ir2, ir1, ir_tdo, bypass_tdo,
                 tdo_sel_ir, shift_dr, capture_dr, update_dr, bs_se, int_se, tlr);
      end
    end
  end

  // Drive one cycle of stimulus and queue the response expected after the next edge.
  task automatic step(input logic r, input logic t, input logic d, input string tag,
                      input logic [4:0] m, input logic [3:0] s, input logic [1:0] ir_e,
                      input logic it, input logic bp, input logic [6:0] c);
    exp_t e;
    @(negedge clock);
    reset = r;
    tms   = t;
    tdi   = d;
    e.tag = tag; e.chk = m; e.st = s; e.ir = ir_e; e.it = it; e.bp = bp; e.ctl = c;
    exp_q.push_back(e);
  endtask

  initial begin
    // reset state
    step(1, 0, 0, "t0_reset", M_ALL, S_TLR, 2'b10, 0, 0, C_TLR);

    // IR load of 11 (captured 01 shifted out LSB first), then Shift-DR decode
    step(0, 0, 0, "t3_rti",     M_S|M_IR|M_C, S_RTI,  2'b10, 0, 0, C_NONE);
    step(0, 1, 0, "t3_seldr",   M_S,          S_SDR,  2'b10, 0, 0, C_NONE);
    step(0, 1, 0, "t3_selir",   M_S,          S_SIR,  2'b10, 0, 0, C_NONE);
    step(0, 0, 0, "t3_capir",   M_S|M_C,      S_CIR,  2'b10, 0, 0, C_NONE);
    step(0, 0, 0, "t3_shir",    M_S|M_IR|M_IT|M_C, S_SHIR, 2'b10, 1, 0, C_SHIR);
    step(0, 0, 1, "t3_shift1",  M_S|M_IR|M_IT|M_C, S_SHIR, 2'b10, 0, 0, C_SHIR);
    step(0, 1, 1, "t3_shift2x", M_S|M_IT|M_C, S_E1IR, 2'b10, 1, 0, C_NONE);
    step(0, 1, 0, "t3_updir",   M_S|M_IR,     S_UIR,  2'b10, 0, 0, C_NONE);
    step(0, 0, 0, "t3_ir11",    M_S|M_IR,     S_RTI,  2'b11, 0, 0, C_NONE);
    step(0, 1, 0, "t3_seldr2",  M_S,          S_SDR,  2'b11, 0, 0, C_NONE);
    step(0, 0, 1, "t3_capdr",   M_S|M_C,      S_CDR,  2'b11, 0, 0, C_CAPDR);
    step(0, 0, 0, "t3_shdr",    M_S|M_BP|M_C, S_SHDR, 2'b11, 0, 0, C_SHDR_INT);
    step(0, 1, 1, "t3_ex1dr",   M_S|M_BP|M_C, S_E1DR, 2'b11, 0, 1, C_NONE);
    step(0, 1, 0, "t3_upddr",   M_S|M_BP|M_C, S_UDR,  2'b11, 0, 1, C_UPDDR);
    step(0, 0, 0, "t3_rti2",    M_S|M_IR,     S_RTI,  2'b11, 0, 0, C_NONE);

    // reset in the middle of Shift-IR
    step(0, 1, 0, "t1_seldr",   M_S,          S_SDR,  2'b11, 0, 0, C_NONE);
    step(0, 1, 0, "t1_selir",   M_S,          S_SIR,  2'b11, 0, 0, C_NONE);
    step(0, 0, 0, "t1_capir",   M_S,          S_CIR,  2'b11, 0, 0, C_NONE);
    step(0, 0, 0, "t1_shir",    M_S|M_IT|M_C, S_SHIR, 2'b11, 1, 0, C_SHIR);
    step(0, 0, 1, "t1_shift",   M_S|M_IT,     S_SHIR, 2'b11, 0, 0, C_NONE);
    step(1, 0, 1, "t1_reset",   M_ALL,        S_TLR,  2'b10, 0, 0, C_TLR);

    // five tms=1 edges reach TLR from RTI
    step(0, 0, 0, "t2_rti",     M_S|M_IR,     S_RTI,  2'b10, 0, 0, C_NONE);
    step(0, 1, 0, "t2_tms1",    M_S,          S_SDR,  2'b10, 0, 0, C_NONE);
    step(0, 1, 0, "t2_tms2",    M_S,          S_SIR,  2'b10, 0, 0, C_NONE);
    step(0, 1, 0, "t2_tms3",    M_S|M_C,      S_TLR,  2'b10, 0, 0, C_TLR);
    step(0, 1, 0, "t2_tms4",    M_S|M_IR,     S_TLR,  2'b10, 0, 0, C_NONE);
    step(0, 1, 0, "t2_tms5",    M_S|M_C,      S_TLR,  2'b10, 0, 0, C_TLR);
    step(0, 0, 0, "t2_back",    M_S|M_C,      S_RTI,  2'b10, 0, 0, C_NONE);

    // BYPASS: captured 0 then tdi delayed by one clock
    step(1, 0, 0, "t4_reset",   M_S|M_BP,     S_TLR,  2'b10, 0, 0, C_NONE);
    step(0, 0, 0, "t4_rti",     M_S,          S_RTI,  2'b10, 0, 0, C_NONE);
    step(0, 1, 0, "t4_seldr",   M_S,          S_SDR,  2'b10, 0, 0, C_NONE);
    step(0, 0, 1, "t4_capdr",   M_S|M_C,      S_CDR,  2'b10, 0, 0, C_CAPDR);
    step(0, 0, 1, "t4_shdr",    M_S|M_BP|M_C, S_SHDR, 2'b10, 0, 0, C_SHDR);
    step(0, 0, 1, "t4_byp1",    M_S|M_BP|M_C, S_SHDR, 2'b10, 0, 1, C_SHDR);
    step(0, 0, 0, "t4_byp0",    M_S|M_BP|M_C, S_SHDR, 2'b10, 0, 0, C_SHDR);
    step(0, 0, 1, "t4_byp1b",   M_S|M_BP|M_C, S_SHDR, 2'b10, 0, 1, C_SHDR);
    step(0, 1, 1, "t4_exit",    M_S|M_BP|M_C, S_E1DR, 2'b10, 0, 1, C_NONE);
    step(0, 1, 0, "t4_upddr",   M_S|M_C,      S_UDR,  2'b10, 0, 0, C_UPDDR);
    step(0, 0, 0, "t4_rti2",    M_S,          S_RTI,  2'b10, 0, 0, C_NONE);

    // Pause-IR holds the shift stage; IR becomes 01 only after Update-IR
    step(0, 1, 0, "t5_seldr",   M_S,          S_SDR,  2'b10, 0, 0, C_NONE);
    step(0, 1, 0, "t5_selir",   M_S,          S_SIR,  2'b10, 0, 0, C_NONE);
    step(0, 0, 0, "t5_capir",   M_S,          S_CIR,  2'b10, 0, 0, C_NONE);
    step(0, 0, 0, "t5_shir",    M_S|M_IT,     S_SHIR, 2'b10, 1, 0, C_NONE);
    step(0, 1, 1, "t5_shiftx",  M_S|M_IT,     S_E1IR, 2'b10, 0, 0, C_NONE);
    step(0, 0, 0, "t5_pause1",  M_S|M_IT|M_IR|M_C, S_PIR, 2'b10, 0, 0, C_NONE);
    step(0, 0, 0, "t5_pause2",  M_S|M_IT|M_IR, S_PIR, 2'b10, 0, 0, C_NONE);
    step(0, 0, 0, "t5_pause3",  M_S|M_IT|M_IR, S_PIR, 2'b10, 0, 0, C_NONE);
    step(0, 1, 0, "t5_ex2ir",   M_S|M_IT,     S_E2IR, 2'b10, 0, 0, C_NONE);
    step(0, 0, 0, "t5_shir2",   M_S|M_IT|M_IR|M_C, S_SHIR, 2'b10, 0, 0, C_SHIR);
    step(0, 1, 0, "t5_shiftx2", M_S|M_IT|M_IR, S_E1IR, 2'b10, 1, 0, C_NONE);
    step(0, 1, 0, "t5_updir",   M_S|M_IR,     S_UIR,  2'b10, 0, 0, C_NONE);
    step(0, 0, 0, "t5_ir01",    M_S|M_IR,     S_RTI,  2'b01, 0, 0, C_NONE);

    // IR=01: bs_se only in Shift-DR, then five tms=1 restore BYPASS
    step(0, 1, 0, "t6_seldr",   M_S|M_C,      S_SDR,  2'b01, 0, 0, C_NONE);
    step(0, 0, 0, "t6_capdr",   M_S|M_C,      S_CDR,  2'b01, 0, 0, C_CAPDR);
    step(0, 0, 1, "t6_shdr",    M_S|M_C,      S_SHDR, 2'b01, 0, 0, C_SHDR_BS);
    step(0, 1, 1, "t6_ex1dr",   M_S|M_C,      S_E1DR, 2'b01, 0, 0, C_NONE);
    step(0, 1, 0, "t6_tms1",    M_S|M_IR|M_C, S_UDR,  2'b01, 0, 0, C_UPDDR);
    step(0, 1, 0, "t6_tms2",    M_S|M_C,      S_SDR,  2'b01, 0, 0, C_NONE);
    step(0, 1, 0, "t6_tms3",    M_S|M_C,      S_SIR,  2'b01, 0, 0, C_NONE);
    step(0, 1, 0, "t6_tms4",    M_S|M_IR|M_C, S_TLR,  2'b01, 0, 0, C_TLR);
    step(0, 1, 0, "t6_tms5",    M_S|M_IR|M_C, S_TLR,  2'b10, 0, 0, C_TLR);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
